// File: rtl/cu_multicycle.sv
// cu_multicycle: multi-cycle fetch/decode/read/exec/writeback control unit for ROM, register RAM and ALU.
// Define CU_BRANCH_EN to enable JMP (1101) and JZ (1110); otherwise both decode as NOP.
module cu_multicycle #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 6,
  parameter int ROM_AW  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      rom_rd,
  output logic [ROM_AW-1:0]         rom_addr,
  input  logic [4+2*RADDR_W-1:0]    rom_data,
  output logic                      ram_rd,
  output logic [RADDR_W-1:0]        ram_rd_addr,
  input  logic [DATA_W-1:0]         ram_rdata,
  output logic                      ram_wr,
  output logic [RADDR_W-1:0]        ram_wr_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  output logic                      alu_en,
  output logic [3:0]                alu_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  output logic [ROM_AW-1:0]         pc,
  output logic                      busy,
  output logic                      halted,
  output logic                      zero_flag
);
  localparam int IW = 4 + 2 * RADDR_W;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, RDA, RDB, EXEC, WB, HALT} state_t;
  state_t               state;
  logic [IW-1:0]        ir;
  logic [DATA_W-1:0]    a_reg, res_reg;
  logic [ROM_AW-1:0]    pc_dec;
  logic [3:0]           rop, iop;
  logic [RADDR_W-1:0]   dst, src;
  logic                 r_alu, i_mov;
  assign rop   = rom_data[IW-1 -: 4];
  assign iop   = ir[IW-1 -: 4];
  assign dst   = ir[2*RADDR_W-1 -: RADDR_W];
  assign src   = ir[RADDR_W-1:0];
  assign r_alu = rop >= 4'd2 && rop <= 4'd11;
  assign i_mov = iop == 4'd1;
`ifdef CU_BRANCH_EN
  // Jump target is the concatenated {dest,src} field resized to the ROM address width.
  assign pc_dec = (rop == 4'hD || (rop == 4'hE && zero_flag)) ? ROM_AW'(rom_data[2*RADDR_W-1:0]) : pc + 1'b1;
`else
  assign pc_dec = pc + 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= '0;
      ir        <= '0;
      a_reg     <= '0;
      res_reg   <= '0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        IDLE:   if (start) state <= FETCH;
        HALT:   if (start) begin
          pc    <= '0;
          state <= FETCH;
        end
        FETCH:  state <= DECODE;
        DECODE: begin
          ir    <= rom_data;
          pc    <= pc_dec;
          if (rop == 4'hC) res_reg <= DATA_W'(rom_data[RADDR_W-1:0]);
          state <= (rop == 4'd1 || r_alu) ? RDA : rop == 4'hC ? WB : rop == 4'hF ? HALT : FETCH;
        end
        RDA:    state <= i_mov ? WB : RDB;
        RDB: begin
          a_reg <= ram_rdata;
          state <= EXEC;
        end
        EXEC: begin
          res_reg   <= alu_result;
          zero_flag <= alu_zero;
          state     <= WB;
        end
        WB:     state <= FETCH;
      endcase
    end
  end
  // Outputs decode only flopped state/IR, so start never reaches a strobe combinationally.
  always_comb begin
    rom_rd      = state == FETCH;
    rom_addr    = rom_rd ? pc : '0;
    ram_rd      = state == RDA || state == RDB;
    ram_rd_addr = state == RDA ? src : state == RDB ? dst : '0;
    ram_wr      = state == WB;
    ram_wr_addr = ram_wr ? dst : '0;
    ram_wdata   = !ram_wr ? '0 : i_mov ? ram_rdata : res_reg;
    alu_en      = state == EXEC;
    alu_op      = alu_en ? iop - 4'd1 : '0;
    alu_a       = alu_en ? a_reg : '0;
    alu_b       = alu_en ? ram_rdata : '0;
    busy        = state != IDLE && state != HALT;
    halted      = state == HALT;
  end
endmodule

// File: tb/tb_cu_multicycle.sv
// tb_cu_multicycle: directed checks of cu_multicycle against behavioural ROM, RAM and ALU models.
module tb_cu_multicycle;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic        rom_rd, ram_rd, ram_wr, alu_en, alu_zero, busy, halted, zero_flag;
  logic [7:0]  rom_addr, pc;
  logic [15:0] rom_data, ram_rdata, ram_wdata, alu_a, alu_b, alu_result;
  logic [5:0]  ram_rd_addr, ram_wr_addr;
  logic [3:0]  alu_op;
  logic [15:0] rom [256];
  logic [15:0] mem [64];
  int          vec = 0, miss = 0, wr_cnt = 0, n, w0;
  always #5 clk = ~clk;
  cu_multicycle dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_rd(ram_rd), .ram_rd_addr(ram_rd_addr), .ram_rdata(ram_rdata),
    .ram_wr(ram_wr), .ram_wr_addr(ram_wr_addr), .ram_wdata(ram_wdata),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .pc(pc), .busy(busy), .halted(halted), .zero_flag(zero_flag)
  );
  always @(posedge clk) begin
    if (rom_rd) rom_data <= rom[rom_addr];
    if (ram_rd) ram_rdata <= mem[ram_rd_addr];
    if (ram_wr) begin
      mem[ram_wr_addr] <= ram_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end
  always_comb begin
    case (alu_op)
      4'd1:    alu_result = alu_a + alu_b;
      4'd2:    alu_result = alu_a - alu_b;
      4'd3:    alu_result = alu_a & alu_b;
      4'd4:    alu_result = alu_a | alu_b;
      4'd5:    alu_result = alu_a ^ alu_b;
      default: alu_result = 16'd0;
    endcase
    alu_zero = alu_result == 16'd0;
  end
  function automatic logic [15:0] ins(input logic [3:0] op, input logic [5:0] d, input logic [5:0] s);
    return {op, d, s};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic run_until_halt(output int c);
    c = 0;
    while (!halted && c < 2000) begin
      step(1);
      c++;
    end
  endtask
  task automatic kick;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("rst_strobes", {rom_rd, ram_rd, ram_wr, alu_en}, 0);
    chk("rst_flags", {busy, halted, zero_flag}, 0);
    chk("rst_pc", pc, 0);
    chk("rst_addr", {rom_addr, ram_rd_addr, ram_wr_addr, alu_op}, 0);
    chk("rst_data", {ram_wdata, alu_a, alu_b}, 0);
    step(3);
    chk("idle_hold", {busy, rom_rd}, 0);
    rom[0] = ins(4'hC, 6'd5, 6'd42);
    rom[1] = ins(4'h1, 6'd7, 6'd5);
    rom[2] = ins(4'hF, 6'd0, 6'd0);
    kick();
    chk("fetch0", {busy, rom_rd, rom_addr}, {2'b11, 8'h00});
    run_until_halt(n);
    chk("mvi_mov_cycles", n, 9);
    chk("mvi_r5", mem[5], 42);
    chk("mov_r7", mem[7], 42);
    chk("halt_pc", pc, 3);
    chk("halt_flags", {halted, busy}, 2'b10);
    step(2);
    chk("halt_hold", {halted, pc}, {1'b1, 8'd3});
    mem[1] = 16'd7;
    mem[2] = 16'd5;
    rom[0] = ins(4'h2, 6'd2, 6'd1);
    rom[1] = ins(4'hF, 6'd0, 6'd0);
    kick();
    chk("restart_pc", {pc, rom_addr}, 0);
    step(4);
    chk("add_exec", {alu_en, alu_op}, {1'b1, 4'd1});
    chk("add_a", alu_a, 7);
    chk("add_b", alu_b, 5);
    step(1);
    chk("add_wb", {ram_wr, ram_wr_addr, ram_wdata}, {1'b1, 6'd2, 16'd12});
    chk("add_zf", zero_flag, 0);
    run_until_halt(n);
    chk("add_tail", n, 3);
    chk("add_r2", mem[2], 12);
    mem[3] = 16'd9;
    mem[4] = 16'd9;
    rom[0] = ins(4'h3, 6'd4, 6'd3);
    rom[1] = ins(4'hE, 6'd0, 6'h20);
    rom[2] = ins(4'hF, 6'd0, 6'd0);
    rom[8'h20] = ins(4'hF, 6'd0, 6'd0);
    kick();
    run_until_halt(n);
    chk("sub_jz_cycles", n, 10);
    chk("sub_r4", mem[4], 0);
    chk("sub_zf", zero_flag, 1);
`ifdef CU_BRANCH_EN
    chk("jz_pc", pc, 8'h21);
`else
    chk("jz_pc", pc, 8'h03);
`endif
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    kick();
    n = 0;
    while (!(rom_rd && rom_addr == 8'hFF) && n < 1000) begin
      step(1);
      n++;
    end
    chk("wrap_reach", {rom_rd, rom_addr}, {1'b1, 8'hFF});
    step(2);
    chk("wrap_fetch0", {rom_rd, rom_addr, pc}, {1'b1, 8'h00, 8'h00});
    rom[0] = ins(4'hF, 6'd0, 6'd0);
    run_until_halt(n);
    chk("wrap_halt", {halted, pc}, {1'b1, 8'd1});
    mem[1] = 16'd7;
    mem[2] = 16'd5;
    rom[0] = ins(4'h2, 6'd2, 6'd1);
    rom[1] = ins(4'hF, 6'd0, 6'd0);
    kick();
    step(4);
    chk("rst_mid_exec", alu_en, 1);
    w0 = wr_cnt;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("rst_mid_state", {busy, halted, ram_wr, alu_en}, 0);
    chk("rst_mid_regs", {pc, zero_flag}, 0);
    step(3);
    chk("rst_mid_nowr", wr_cnt, w0);
    chk("rst_mid_r2", mem[2], 5);
    chk("rst_mid_idle", busy, 0);
    rom[0] = ins(4'hF, 6'd0, 6'd0);
    kick();
    chk("idle_start", {rom_rd, rom_addr}, {1'b1, 8'h00});
    run_until_halt(n);
    chk("halt_only", {n[7:0], pc}, {8'd2, 8'd1});
    kick();
    chk("halt_start", {rom_rd, rom_addr, pc}, {1'b1, 8'h00, 8'h00});
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/cu_multicycle.md
# cu_multicycle

Parametrised multi-cycle control unit: the successor to the single-cycle combinational decoder. It fetches instructions from the synchronous program ROM, decodes them, and sequences operand reads from the register RAM. It also drives the ALU and writes results back, using an explicit state machine with a program counter. The block sits between the ROM, RAM and ALU instances at the CPU top level; the memories and the ALU are external to it.

## Interface
Parameters:
- DATA_W, 16, register/ALU data width (must be ≥ RADDR_W)
- RADDR_W, 6, register address width; instruction width is 4 + 2·RADDR_W
- ROM_AW, 8, program ROM address width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  leave IDLE/HALT and begin execution
- rom_rd  out  1  ROM read enable
- rom_addr  out  ROM_AW  ROM address (= pc)
- rom_data  in  4+2·RADDR_W  instruction {opcode[3:0], dest, src}; valid the cycle after rom_rd
- ram_rd  out  1  RAM read enable
- ram_rd_addr  out  RADDR_W  RAM read address
- ram_rdata  in  DATA_W  RAM read data; valid the cycle after ram_rd
- ram_wr  out  1  RAM write enable
- ram_wr_addr  out  RADDR_W  RAM write address
- ram_wdata  out  DATA_W  RAM write data
- alu_en  out  1  ALU enable
- alu_op  out  4  ALU operation code
- alu_a, alu_b  out  DATA_W  ALU operands
- alu_result  in  DATA_W  ALU result (combinational)
- alu_zero  in  1  ALU zero flag
- pc  out  ROM_AW  program counter
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- zero_flag  out  1  alu_zero captured at the last EXEC

## Operation
- States: IDLE, FETCH, DECODE, RDA, RDB, EXEC, WB, HALT.
- IDLE → FETCH when start=1.
- FETCH: rom_rd=1, rom_addr=pc.
- DECODE: latch rom_data into IR. pc ← pc+1, wrapping 2^ROM_AW−1 → 0.
- Opcodes:
  - 0000 NOP: DECODE → FETCH.
  - 0001 MOV: RDA reads R[src]. In WB, ram_wdata = ram_rdata and ram_wr_addr = dest.
  - 0010–1011 ALU ops (ADD, SUB, AND, OR, XOR, NOT, SHL, SHR, LT, EQ): alu_op = opcode−1.
    - RDA reads R[src].
    - RDB reads R[dest] and latches ram_rdata into a_reg.
    - EXEC: alu_a = a_reg, alu_b = ram_rdata, alu_en=1; latch alu_result into res_reg and alu_zero into zero_flag.
    - WB writes res_reg to dest.
  - 1100 MVI: DECODE → WB. ram_wdata = src field zero-extended to DATA_W.
  - 1111 HALT: DECODE → HALT.
  - 1101, 1110: see Configuration. All other codes: NOP.
- WB → FETCH.
- HALT: holds. start=1 sets pc ← 0 and moves to FETCH.
- Strobes (rom_rd, ram_rd, ram_wr, alu_en) are high only in the states named above. Their address/data outputs are 0 whenever the strobe is low.
- rst_n=0 at any state, including mid-instruction:
  - next edge: state=IDLE; pc, IR, a_reg, res_reg, zero_flag and all outputs = 0.
  - an in-flight write is dropped.

## Timing
- Registered outputs, each a function of the current state and IR only. No combinational path from start to any strobe.
- Cycles per instruction, including fetch:
  - NOP/jump: 2
  - MVI: 3
  - MOV: 4
  - ALU ops: 6
  - HALT: 2, then resident in HALT.
- start is sampled only in IDLE/HALT and ignored while busy.
- Reading and writing the same register in one instruction is safe: the read completes before WB.
- zero_flag changes only in EXEC.

## Configuration
- CU_BRANCH_EN defined:
  - 1101 JMP: pc ← {dest,src}, truncated or zero-extended to ROM_AW.
  - 1110 JZ: the same load only if zero_flag=1, otherwise pc+1.
  - Both take DECODE → FETCH, 2 cycles.
- Not defined: 1101/1110 execute as NOP.

## Test plan
- Reset: rst_n low for 2 cycles, then high with start=0 → all outputs 0, state IDLE, busy=0.
- MVI R5,#42; MOV R7,R5; HALT → RAM[7]=42. Total 3+4+2 cycles from FETCH, then halted=1, pc=3.
- With R1=7, R2=5: ADD R2,R1 → alu_a=7, alu_b=5, alu_op=0001 in EXEC; RAM[2]=12 written in cycle 6; zero_flag=0.
- With R3=R4=9: SUB R4,R3 → RAM[4]=0, zero_flag=1.
  - With CU_BRANCH_EN: a following JZ to 0x20 → pc=0x20.
  - Without it: pc increments.
- PC wrap: ROM_AW=8, NOP at address 255 → next fetch at 0.
- Assert rst_n low during EXEC of an ADD → no ram_wr pulse, state IDLE. HALT then start → pc=0 and fetch resumes.
